// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage directly upstream of instruction_memory.
// Owns the PC, presents it as the memory address, and captures {pc, instr}
// from the combinational memory into an IF/ID register. The register uses a
// valid/ready handshake toward the decoder. Redirects from later stages flush
// the register and retarget the PC.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   imem_addr        byte address to instruction memory (= pc)
//   imem_instr       instruction word for imem_addr, same cycle
//   redirect_valid   taken branch/jump strobe
//   redirect_pc      redirect target; low two bits are dropped
//   out_valid/ready  IF/ID handshake toward decode
//   out_pc, out_instr, out_pc_plus4   IF/ID payload
//   misaligned       one-cycle pulse after a redirect with redirect_pc[1:0] != 0
//   fetch_count      number of completed handshakes (wraps)
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;

  // PC is held as a word index so the low two bits are zero by construction.
  logic [29:0] pc_w;
  logic [31:0] pc;
  logic [31:0] pc_next4;
  ifid_t       ifid;
  logic        vld;
  logic        advance;
  logic        xfer;

  assign pc        = {pc_w, 2'b00};
  assign pc_next4  = pc + 32'd4;  // wraps 0xFFFF_FFFC -> 0
  assign imem_addr = pc;

  // Empty register can always be filled; full one only when decode drains it.
  assign advance = !vld || out_ready;
  assign xfer    = vld && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_w      <= RESET_PC[31:2];
      vld       <= 1'b0;
      ifid      <= '{pc: 32'd0, instr: NOP_INSTR, pc_plus4: 32'd0};
    end else if (redirect_valid) begin
      // Flush: whatever would have been captured this cycle is squashed.
      pc_w       <= redirect_pc[31:2];
      vld        <= 1'b0;
      ifid.instr <= NOP_INSTR;
    end else if (advance) begin
      pc_w      <= pc_next4[31:2];
      vld       <= 1'b1;
      ifid      <= '{pc: pc, instr: imem_instr, pc_plus4: pc_next4};
    end
  end

  // Handshake counter is independent of flushes: an entry accepted in the
  // same cycle as a redirect was still delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'd0;
    end else if (xfer) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  // Re-evaluated every cycle so it falls after one cycle unless another
  // misaligned redirect arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned <= 1'b0;
    end else begin
      misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  assign out_valid    = vld;
  assign out_pc       = ifid.pc;
  assign out_instr    = ifid.instr;
  assign out_pc_plus4 = ifid.pc_plus4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. The memory model returns
// addr + 0x100 combinationally. Directed vectors are applied on the falling
// edge and checked 1ns after the following rising edge. Hand sequences cover
// the asynchronous reset while stalled.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic        misaligned;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch #(.RESET_PC(32'h0), .NOP_INSTR(32'h13)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_pc_plus4(out_pc_plus4),
    .misaligned(misaligned), .fetch_count(fetch_count)
  );

  assign imem_instr = imem_addr + 32'h100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [31:0] e_addr;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                     input logic [31:0] ep4, input logic [31:0] ead,
                     input logic emis, input logic [31:0] ecnt);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.e_valid = ev; v.e_pc = epc;
    v.e_instr = ein; v.e_pc4 = ep4; v.e_addr = ead; v.e_mis = emis; v.e_cnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " out_valid"},    {31'd0, out_valid},  32'd0);
    chk({tag, " out_pc"},       out_pc,              32'd0);
    chk({tag, " out_pc_plus4"}, out_pc_plus4,        32'd0);
    chk({tag, " out_instr"},    out_instr,           32'h13);
    chk({tag, " imem_addr"},    imem_addr,           32'd0);
    chk({tag, " misaligned"},   {31'd0, misaligned}, 32'd0);
    chk({tag, " fetch_count"},  fetch_count,         32'd0);
  endtask

  initial begin
    //   rv rpc            rdy  valid pc            instr         pc4           addr          mis cnt
    add(0, 32'h0,          1,   1, 32'h0,          32'h100,      32'h4,        32'h4,        0, 0); // fill
    add(0, 32'h0,          1,   1, 32'h4,          32'h104,      32'h8,        32'h8,        0, 1);
    add(0, 32'h0,          1,   1, 32'h8,          32'h108,      32'hC,        32'hC,        0, 2);
    add(0, 32'h0,          0,   1, 32'h8,          32'h108,      32'hC,        32'hC,        0, 2); // stall x4
    add(0, 32'h0,          0,   1, 32'h8,          32'h108,      32'hC,        32'hC,        0, 2);
    add(0, 32'h0,          0,   1, 32'h8,          32'h108,      32'hC,        32'hC,        0, 2);
    add(0, 32'h0,          0,   1, 32'h8,          32'h108,      32'hC,        32'hC,        0, 2);
    add(0, 32'h0,          1,   1, 32'hC,          32'h10C,      32'h10,       32'h10,       0, 3); // resume
    add(0, 32'h0,          0,   1, 32'hC,          32'h10C,      32'h10,       32'h10,       0, 3);
    add(1, 32'h40,         0,   0, 32'h0,          32'h13,       32'h0,        32'h40,       0, 3); // redirect, stalled
    add(0, 32'h0,          0,   1, 32'h40,         32'h140,      32'h44,       32'h44,       0, 3);
    add(1, 32'h42,         1,   0, 32'h0,          32'h13,       32'h0,        32'h40,       1, 4); // redirect + xfer, misaligned
    add(0, 32'h0,          1,   1, 32'h40,         32'h140,      32'h44,       32'h44,       0, 4);
    add(1, 32'h43,         1,   0, 32'h0,          32'h13,       32'h0,        32'h40,       1, 5); // 0x43 then 0x80
    add(1, 32'h80,         1,   0, 32'h0,          32'h13,       32'h0,        32'h80,       0, 5);
    add(0, 32'h0,          1,   1, 32'h80,         32'h180,      32'h84,       32'h84,       0, 5);
    add(1, 32'hFFFF_FFFC,  0,   0, 32'h0,          32'h13,       32'h0,        32'hFFFF_FFFC,0, 5); // wrap
    add(0, 32'h0,          1,   1, 32'hFFFF_FFFC,  32'hFC,       32'h0,        32'h0,        0, 5);
    add(0, 32'h0,          1,   1, 32'h0,          32'h100,      32'h4,        32'h4,        0, 6);
    add(0, 32'h0,          0,   1, 32'h0,          32'h100,      32'h4,        32'h4,        0, 6);
    add(1, 32'h42,         0,   0, 32'h0,          32'h13,       32'h0,        32'h40,       1, 6); // b2b misaligned
    add(1, 32'h46,         0,   0, 32'h0,          32'h13,       32'h0,        32'h44,       1, 6);
    add(0, 32'h0,          0,   1, 32'h44,         32'h144,      32'h48,       32'h48,       0, 6);
    add(0, 32'h0,          0,   1, 32'h44,         32'h144,      32'h48,       32'h48,       0, 6); // stalled full

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset_state("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d out_instr", i), out_instr, vecs[i].e_instr);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("v%0d out_pc_plus4", i), out_pc_plus4, vecs[i].e_pc4);
      end
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d misaligned", i), {31'd0, misaligned}, {31'd0, vecs[i].e_mis});
      chk($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].e_cnt);
      @(negedge clk);
    end

    // Asynchronous reset between edges while stalled with a valid entry
    // and a redirect pending on the inputs.
    redirect_valid = 1'b1; redirect_pc = 32'h200; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_state("async");
    redirect_valid = 1'b0;
    @(posedge clk);
    #1 chk_reset_state("held");
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset out_valid", {31'd0, out_valid}, 32'd1);
    chk("post-reset out_pc", out_pc, 32'h0);
    chk("post-reset out_instr", out_instr, 32'h100);
    chk("post-reset imem_addr", imem_addr, 32'h4);
    @(posedge clk);
    #1;
    chk("post-reset 2nd out_pc", out_pc, 32'h4);
    chk("post-reset fetch_count", fetch_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
